pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipeline_ctrl_wait_timer.sv | 34 +++
 rtl/pipeline_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Optional feature macro used by the controller: PIPE_PERF_CNT_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERROR    = 2'd3
  } pipe_state_t;

  localparam int NUM_STAGES = 5;
  localparam int PERF_W     = 16;

  // Enable-vector bit positions, IF is the most significant stage
  localparam int STG_IF  = 4;
  localparam int STG_ID  = 3;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 0;

  localparam logic [NUM_STAGES-1:0] EN_NONE    = 5'b00000;
  localparam logic [NUM_STAGES-1:0] EN_ALL     = 5'b11111;
  localparam logic [NUM_STAGES-1:0] EN_WB_ONLY = 5'b00001;
  localparam logic [NUM_STAGES-1:0] EN_STALL   = 5'b00111;

endpackage

// File: rtl/pipeline_ctrl_wait_timer.sv
// Memory-wait cycle counter: load starts the count at 1, inc advances it,
// expired flags that the current count has reached the limit.
module wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = 8'd1;
    end else if (inc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control FSM: stalls, flushes, memory waits, halt and error.
// Define PIPE_PERF_CNT_EN to add saturating stall_cycles / flush_count outputs.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        en_if,
  output logic        en_id,
  output logic        en_ex,
  output logic        en_mem,
  output logic        en_wb,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic [1:0]  state,
  output logic        halted,
`ifdef PIPE_PERF_CNT_EN
  output logic        err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`else
  output logic        err
`endif
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  pipe_state_t           state_q, state_d;
  logic                  pend_branch_q, pend_branch_d;
  logic [NUM_STAGES-1:0] en_vec;
  logic                  fl_id, fl_ex, fl_mem;
  logic                  tmr_load, tmr_inc, tmr_expired;

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .limit   (TIMEOUT_LIM),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    pend_branch_d = pend_branch_q;
    en_vec        = EN_NONE;
    fl_id         = 1'b0;
    fl_ex         = 1'b0;
    fl_mem        = 1'b0;
    tmr_load      = 1'b0;
    tmr_inc       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          en_vec  = EN_WB_ONLY;
          state_d = ST_HALT;
        end else if (mem_req && !mem_ready) begin
          tmr_load = 1'b1;
          state_d  = ST_MEM_WAIT;
        end else if (branch_taken) begin
          en_vec = EN_ALL;
          fl_id  = 1'b1;
          fl_ex  = 1'b1;
          fl_mem = 1'b1;
        end else if (stall_req) begin
          en_vec = EN_STALL;
          fl_ex  = 1'b1;
        end else begin
          en_vec = EN_ALL;
        end
      end
      ST_MEM_WAIT: begin
        // mem_ready wins over a simultaneous timeout
        if (mem_ready) begin
          en_vec        = EN_ALL;
          fl_id         = pend_branch_q | branch_taken;
          fl_ex         = pend_branch_q | branch_taken;
          fl_mem        = pend_branch_q | branch_taken;
          pend_branch_d = 1'b0;
          state_d       = ST_RUN;
        end else begin
          if (branch_taken) begin
            pend_branch_d = 1'b1;
          end
          if (tmr_expired) begin
            state_d = ST_ERROR;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Everything is held quiet while reset is asserted
    if (rst) begin
      en_vec = EN_NONE;
      fl_id  = 1'b0;
      fl_ex  = 1'b0;
      fl_mem = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pend_branch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_branch_q <= pend_branch_d;
    end
  end

  assign en_if     = en_vec[STG_IF];
  assign en_id     = en_vec[STG_ID];
  assign en_ex     = en_vec[STG_EX];
  assign en_mem    = en_vec[STG_MEM];
  assign en_wb     = en_vec[STG_WB];
  assign flush_id  = fl_id;
  assign flush_ex  = fl_ex;
  assign flush_mem = fl_mem;
  assign state     = state_q;
  assign halted    = (state_q == ST_HALT) & ~rst;
  assign err       = (state_q == ST_ERROR) & ~rst;

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!en_if && (state_q != ST_HALT) && (state_q != ST_ERROR)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (flush_id) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (MEM_TIMEOUT 255 and 3) driven in
// lockstep, directed scenarios followed by random traffic against a model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic stall_req, branch_taken, mem_req, mem_ready, halt_req, resume;

  logic       en_if  [2];
  logic       en_id  [2];
  logic       en_ex  [2];
  logic       en_mem [2];
  logic       en_wb  [2];
  logic       fl_id  [2];
  logic       fl_ex  [2];
  logic       fl_mem [2];
  logic [1:0] st     [2];
  logic       hlt    [2];
  logic       er     [2];
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cyc [2];
  logic [15:0] flush_cnt [2];
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .en_if(en_if[0]), .en_id(en_id[0]), .en_ex(en_ex[0]), .en_mem(en_mem[0]), .en_wb(en_wb[0]),
    .flush_id(fl_id[0]), .flush_ex(fl_ex[0]), .flush_mem(fl_mem[0]),
    .state(st[0]), .halted(hlt[0]),
`ifdef PIPE_PERF_CNT_EN
    .err(er[0]), .stall_cycles(stall_cyc[0]), .flush_count(flush_cnt[0])
`else
    .err(er[0])
`endif
  );

  pipeline_ctrl #(.MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
    .en_if(en_if[1]), .en_id(en_id[1]), .en_ex(en_ex[1]), .en_mem(en_mem[1]), .en_wb(en_wb[1]),
    .flush_id(fl_id[1]), .flush_ex(fl_ex[1]), .flush_mem(fl_mem[1]),
    .state(st[1]), .halted(hlt[1]),
`ifdef PIPE_PERF_CNT_EN
    .err(er[1]), .stall_cycles(stall_cyc[1]), .flush_count(flush_cnt[1])
`else
    .err(er[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 run, 1 waiting on memory, 2 halted, 3 error
  int tmo    [2] = '{255, 3};
  int mode   [2];
  int waited [2];
  bit pend   [2];
  int pstall [2];
  int pflush [2];
  int n_mode [2];
  int n_wait [2];
  bit n_pend [2];
  int n_stall[2];
  int n_flush[2];

  function automatic logic [11:0] observed(input int i);
    return {st[i], en_if[i], en_id[i], en_ex[i], en_mem[i], en_wb[i],
            fl_id[i], fl_ex[i], fl_mem[i], hlt[i], er[i]};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; waited[i] = 0; pend[i] = 1'b0; pstall[i] = 0; pflush[i] = 0;
    end
  endtask

  // Expected outputs this cycle and the model's next state, from the rules
  task automatic model_eval(input int i, output logic [11:0] e);
    logic [4:0] en;
    logic [2:0] fl;
    logic h, x;
    en = 5'b0; fl = 3'b0; h = 1'b0; x = 1'b0;
    n_mode[i] = mode[i]; n_wait[i] = waited[i]; n_pend[i] = pend[i];
    case (mode[i])
      0: begin
        if (halt_req) begin
          en = 5'b00001; n_mode[i] = 2;
        end else if (mem_req && !mem_ready) begin
          n_mode[i] = 1; n_wait[i] = 1;
        end else if (branch_taken) begin
          en = 5'b11111; fl = 3'b111;
        end else if (stall_req) begin
          en = 5'b00111; fl = 3'b010;
        end else begin
          en = 5'b11111;
        end
      end
      1: begin
        if (mem_ready) begin
          en = 5'b11111;
          if (pend[i] || branch_taken) fl = 3'b111;
          n_pend[i] = 1'b0; n_mode[i] = 0;
        end else begin
          if (branch_taken) n_pend[i] = 1'b1;
          if (waited[i] == tmo[i]) n_mode[i] = 3;
          else n_wait[i] = waited[i] + 1;
        end
      end
      2: begin
        h = 1'b1;
        if (resume) n_mode[i] = 0;
      end
      default: x = 1'b1;
    endcase
    e = {mode[i][1:0], en, fl, h, x};
    n_stall[i] = pstall[i];
    n_flush[i] = pflush[i];
    if (!en[4] && mode[i] != 2 && mode[i] != 3 && pstall[i] < 65535) n_stall[i] = pstall[i] + 1;
    if (fl[2] && pflush[i] < 65535) n_flush[i] = pflush[i] + 1;
  endtask

  task automatic step(input string tag, input bit s, input bit b, input bit mq,
                      input bit mr, input bit hq, input bit rs);
    logic [11:0] e;
    stall_req = s; branch_taken = b; mem_req = mq; mem_ready = mr;
    halt_req = hq; resume = rs;
    #2;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, e);
      chk($sformatf("%s[%0d]", tag, i), observed(i), e);
`ifdef PIPE_PERF_CNT_EN
      chk16($sformatf("%s_stall[%0d]", tag, i), stall_cyc[i], 16'(pstall[i]));
      chk16($sformatf("%s_flush[%0d]", tag, i), flush_cnt[i], 16'(pflush[i]));
`endif
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mode[i] = n_mode[i]; waited[i] = n_wait[i]; pend[i] = n_pend[i];
      pstall[i] = n_stall[i]; pflush[i] = n_flush[i];
    end
    #1;
  endtask

  // Reset is raised between edges to exercise the asynchronous path
  task automatic do_reset(input string tag);
    stall_req = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    halt_req = 0; resume = 0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("%s[%0d]", tag, i), observed(i), 12'h000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall_req = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    halt_req = 0; resume = 0;
    model_reset();
    #3;
    for (int i = 0; i < 2; i++) chk($sformatf("in_reset[%0d]", i), observed(i), 12'h000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: run with everything enabled
    for (int k = 0; k < 3; k++) step("idle", 0, 0, 0, 0, 0, 0);
    checks++;
    assert (observed(0) === 12'b00_11111_000_0_0) else begin
      errors++;
      $error("FAIL idle_run observed=%h expected=%h", observed(0), 12'b00_11111_000_0_0);
    end

    // Single load-use stall
    step("stall", 1, 0, 0, 0, 0, 0);
    step("after_stall", 0, 0, 0, 0, 0, 0);
    // Branch outranks stall
    step("br_over_stall", 1, 1, 0, 0, 0, 0);
    // Memory ready in the request cycle: no wait
    step("mem_hit", 0, 0, 1, 1, 0, 0);

    // Memory miss for 4 cycles with a branch in cycle 2, then ready
    step("miss1", 0, 0, 1, 0, 0, 0);
    step("miss2_br", 0, 1, 0, 0, 0, 0);
    step("miss3", 0, 0, 0, 0, 0, 0);
    step("miss4", 0, 0, 0, 0, 0, 0);
    step("miss_ready", 0, 0, 0, 1, 0, 0);
    step("miss_after", 0, 0, 0, 0, 0, 0);

    // Timeout on the short-limit instance, then reset recovers it
    do_reset("rst_pre_to");
    step("to_req", 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("to_wait", 0, 0, 0, 0, 0, 0);
    step("to_err", 0, 0, 0, 0, 0, 0);
    checks++;
    assert (er[1] === 1'b1 && st[1] === 2'd3) else begin
      errors++;
      $error("FAIL timeout_err observed=%b/%0d expected=1/3", er[1], st[1]);
    end
    step("to_stuck", 0, 1, 1, 0, 1, 1);
    do_reset("rst_from_err");
    step("post_err", 0, 0, 0, 0, 0, 0);

    // Ready on the exact timeout cycle resolves to run
    step("edge_req", 0, 0, 1, 0, 0, 0);
    step("edge_w1", 0, 0, 0, 0, 0, 0);
    step("edge_w2", 0, 0, 0, 0, 0, 0);
    step("edge_ready", 0, 0, 0, 1, 0, 0);
    step("edge_run", 0, 0, 0, 0, 0, 0);

    // Halt together with a branch, halt ignored while halted, then resume
    step("halt_br", 0, 1, 0, 0, 1, 0);
    step("halted", 0, 0, 0, 0, 1, 0);
    step("resume", 0, 0, 0, 0, 0, 1);
    step("resumed", 0, 0, 0, 0, 0, 0);

    // Reset mid-wait drops the pending branch and the count
    step("mw_req", 0, 0, 1, 0, 0, 0);
    step("mw_br", 0, 1, 0, 0, 0, 0);
    do_reset("rst_mid_wait");
    step("mw_fresh", 0, 0, 1, 0, 0, 0);
    step("mw_fresh_rdy", 0, 0, 0, 1, 0, 0);

`ifdef PIPE_PERF_CNT_EN
    do_reset("rst_perf");
    step("perf_s1", 1, 0, 0, 0, 0, 0);
    step("perf_s2", 1, 0, 0, 0, 0, 0);
    step("perf_br", 0, 1, 0, 0, 0, 0);
    step("perf_idle", 0, 0, 0, 0, 0, 0);
    chk16("perf_stall2", stall_cyc[0], 16'd2);
    chk16("perf_flush1", flush_cnt[0], 16'd1);
    stall_req = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk16("perf_stall_sat", stall_cyc[0], 16'hFFFF);
    do_reset("rst_after_sat");
`endif

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
